// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, lamp constants and countdown width shared by the traffic sequencer.
package traffic_pkg;
  localparam int CW = 8;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5,
    WALK      = 3'd6
  } state_e;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  function automatic logic [2:0] ns_lamp(input state_e s);
    return s == NS_GREEN ? GREEN : s == NS_YELLOW ? YELLOW : RED;
  endfunction
  function automatic logic [2:0] ew_lamp(input state_e s);
    return s == EW_GREEN ? GREEN : s == EW_YELLOW ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter that steps on tick and holds at zero.
module phase_timer
  import traffic_pkg::*;
(
  input  logic          clk,
  input  logic          load,
  input  logic          tick,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] value,
  output logic          done
);
  logic [CW-1:0] value_q, value_d;
  always_comb value_d = load ? load_val : (tick && value_q != '0) ? value_q - CW'(1) : value_q;
  always_ff @(posedge clk) value_q <= value_d;
  assign value = value_q;
  assign done  = value_q == '0;
endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: two-way intersection light FSM with optional pedestrian walk phase.
// Define PED_WALK_EN to enable the WALK phase; otherwise ped_req is ignored and ped_walk is 0.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          ped_req,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          ped_walk,
  output logic [CW-1:0] countdown,
  output logic [2:0]    phase
);
  state_e state_q, state_d;
  logic dir_q, dir_d, ped_pend, done, adv, load, walk_entry;
  logic [2:0] ns_q, ew_q;
  logic [CW-1:0] load_val;
  function automatic logic [CW-1:0] len(input state_e s);
    return (s == NS_GREEN || s == EW_GREEN) ? CW'(GREEN_T - 1) :
           (s == NS_YELLOW || s == EW_YELLOW) ? CW'(YELLOW_T - 1) :
           s == WALK ? CW'(WALK_T - 1) : CW'(ALLRED_T - 1);
  endfunction
  assign adv = tick && done;
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if (adv) state_d = NS_YELLOW;
      NS_YELLOW: if (adv) state_d = RED_A;
      RED_A:     if (adv) state_d = ped_pend ? WALK : EW_GREEN;
      EW_GREEN:  if (adv) state_d = EW_YELLOW;
      EW_YELLOW: if (adv) state_d = RED_B;
      RED_B:     if (adv) state_d = ped_pend ? WALK : NS_GREEN;
      WALK:      if (adv) state_d = dir_q ? NS_GREEN : EW_GREEN;
      default:   state_d = NS_GREEN;
    endcase
  end
  // dir remembers which clearance led into WALK so the walk resumes the right direction
  assign walk_entry = state_d == WALK && state_q != WALK;
  assign dir_d      = walk_entry ? state_q == RED_B : dir_q;
  assign load       = !rst_n || state_d != state_q;
  assign load_val   = len(rst_n ? state_d : NS_GREEN);
  phase_timer u_timer (
    .clk      (clk),
    .load     (load),
    .tick     (tick),
    .load_val (load_val),
    .value    (countdown),
    .done     (done)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NS_GREEN;
      dir_q   <= 1'b0;
      ns_q    <= GREEN;
      ew_q    <= RED;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ns_q    <= ns_lamp(state_d);
      ew_q    <= ew_lamp(state_d);
    end
  end
`ifdef PED_WALK_EN
  logic ped_q, walk_q;
  always_ff @(posedge clk) begin
    ped_q  <= rst_n && (ped_req || (ped_q && !walk_entry));
    walk_q <= rst_n && state_d == WALK;
  end
  assign ped_pend = ped_q;
  assign ped_walk = walk_q;
`else
  logic unused_ped;
  assign unused_ped = ped_req;
  assign ped_pend   = 1'b0;
  assign ped_walk   = 1'b0;
`endif
  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign phase    = state_q;
endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 The block SHALL have parameter GREEN_T, default 30, green phase length in ticks (1..255).
REQ-002 The block SHALL have parameter YELLOW_T, default 3, yellow phase length in ticks (1..255).
REQ-003 The block SHALL have parameter ALLRED_T, default 2, all-red clearance length in ticks (1..255).
REQ-004 The block SHALL have parameter WALK_T, default 10, pedestrian walk length in ticks (1..255).
REQ-005 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 The block SHALL have port tick, input, 1, single-cycle enable pulse, nominally 1 Hz, from the clock divider.
REQ-008 The block SHALL have port ped_req, input, 1, pedestrian request, sampled every clk cycle.
REQ-009 The block SHALL have port ns_light, output, 3, {red,yellow,green} for north-south, one-hot.
REQ-010 The block SHALL have port ew_light, output, 3, {red,yellow,green} for east-west, one-hot.
REQ-011 The block SHALL have port ped_walk, output, 1, high only in the WALK state.
REQ-012 The block SHALL have port countdown, output, 8, ticks remaining in the current phase minus one.
REQ-013 The block SHALL have port phase, output, 3, encoded current state.

Function
REQ-014 The FSM SHALL have states NS_GREEN=0, NS_YELLOW=1, RED_A=2, EW_GREEN=3, EW_YELLOW=4, RED_B=5, WALK=6.
REQ-015 Order without pending request: NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> NS_GREEN.
REQ-016 Leaving RED_A or RED_B with ped_pending=1 SHALL go to WALK; WALK then exits to EW_GREEN (from RED_A) or NS_GREEN (from RED_B), tracked by a direction bit.
REQ-017 On state entry countdown SHALL load the phase length minus 1; on each tick with countdown>0 it decrements.
REQ-018 A tick with countdown==0 SHALL cause the transition in the same cycle; each phase therefore lasts exactly its length in ticks.
REQ-019 Cycles without tick SHALL hold state and countdown unchanged.
REQ-020 Light outputs: the active direction shows green/yellow and the other shows red; RED_A, RED_B and WALK show red on both.
REQ-021 All outputs SHALL be registered and SHALL change on the same edge as the state change.
REQ-022 ped_req=1 SHALL set ped_pending; ped_pending clears on WALK entry; simultaneous set and clear SHALL leave it set (set wins).
REQ-023 ped_req asserted during WALK SHALL give another WALK at the next RED_A/RED_B, not an extension of the current walk.
REQ-024 Unused state encoding 7 SHALL recover to NS_GREEN with countdown GREEN_T-1 on the next clk.

Reset
REQ-025 With rst_n=0 at a clk edge: state NS_GREEN, countdown GREEN_T-1, ped_pending 0, direction 0, ns_light=001, ew_light=100, ped_walk 0, phase 0.
REQ-026 Reset SHALL take priority over tick and ped_req and SHALL abort any phase mid-count.

Configuration
REQ-027 With PED_WALK_EN defined, REQ-016/022/023 apply.
REQ-028 Without PED_WALK_EN, ped_req SHALL be ignored, WALK SHALL be unreachable, ped_walk SHALL be tied 0, and the port list SHALL be unchanged.

Structure
REQ-029 The state encoding enum, the light constants (RED=100, YELLOW=010, GREEN=001) and the countdown width SHALL be placed in shared package traffic_pkg.
REQ-030 The countdown SHALL be implemented as sub-module phase_timer (load, tick, value, done); the FSM stays in traffic_sequencer.

Verification
REQ-031 Use GREEN_T=4, YELLOW_T=2, ALLRED_T=1, WALK_T=3 and tick every 5 clk cycles.
REQ-032 Reset, no ped_req -> phases 0,1,2,3,4,5,0 with lengths 4,2,1,4,2,1 ticks; countdown runs 3..0 in NS_GREEN.
REQ-033 ped_req pulse during NS_GREEN -> RED_A, then WALK for 3 ticks with ped_walk=1 and both lights 100, then EW_GREEN; no further WALK follows.
REQ-034 ped_req on the WALK-entry cycle -> ped_pending stays 1; WALK occurs again after RED_B.
REQ-035 rst_n=0 for 1 cycle mid EW_YELLOW -> next cycle phase 0, countdown 3, ns_light=001.
REQ-036 Tick held low for 100 cycles -> state and countdown frozen; build without PED_WALK_EN plus ped_req -> phase never reaches 6.
